// File: rtl/wb_trace_pkg.sv
// Shared definitions for the write-back trace checker: error codes, FSM encoding, trace entry layout.
// Latency: none (declarations and a pure compare function only).
// Backpressure: not applicable.
package wb_trace_pkg;

    localparam int PC_W    = 32;
    localparam int RA_W    = 5;
    localparam int WD_W    = 32;
    localparam int ENTRY_W = PC_W + RA_W + WD_W;   // 69-bit {pc, addr, wdata}

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_PC   = 2'b01;
    localparam logic [1:0] ERR_ADDR = 2'b10;
    localparam logic [1:0] ERR_DATA = 2'b11;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_PASS = 2'b10;
    localparam logic [1:0] S_FAIL = 2'b11;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [RA_W-1:0] addr;
        logic [WD_W-1:0] wdata;
    } trace_entry_t;

    // First differing field wins, pc before addr before wdata.
    function automatic logic [1:0] cmp_entry(input trace_entry_t got, input trace_entry_t gold);
        if (got.pc != gold.pc)
            return ERR_PC;
        else if (got.addr != gold.addr)
            return ERR_ADDR;
        else if (got.wdata != gold.wdata)
            return ERR_DATA;
        else
            return ERR_NONE;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Small synchronous FIFO holding trace entries; head is presented combinationally.
// Latency: a push is visible at the head the cycle after the pushing edge.
// Backpressure: push is dropped when full unless a pop happens at the same edge; pop on empty is ignored.
module trace_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/wb_trace_checker.sv
// Compares each architectural register write from the CPU trace against a golden ROM trace; latches first mismatch.
// Latency: an event sampled at edge N with its golden entry ready is compared in cycle N+1; result visible after edge N+1.
// Backpressure: none toward the CPU; events wait in a queue until golden data arrives, golden reads throttle on a 2-entry queue.
module wb_trace_checker
    import wb_trace_pkg::*;
#(
    parameter int TRACE_LEN = 1024,
    parameter int IDX_W     = 10,
    parameter int EVQ_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      debug_wb_pc,
    input  logic             debug_wb_rf_wen,
    input  logic [4:0]       debug_wb_rf_addr,
    input  logic [31:0]      debug_wb_rf_wdata,
    output logic             golden_rd_en,
    output logic [IDX_W-1:0] golden_rd_idx,
    input  logic [31:0]      golden_pc,
    input  logic [4:0]       golden_addr,
    input  logic [31:0]      golden_wdata,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       err_code,
    output logic [31:0]      events_checked,
    output logic [31:0]      mm_pc,
    output logic [31:0]      mm_got,
    output logic [31:0]      mm_exp
);

    logic [1:0]       state;
    logic             active;
    logic             ev_push;
    logic             ev_empty;
    logic             ev_full;
    logic             exp_empty;
    logic             exp_full;
    logic             cmp_fire;
    logic             inflight;
    logic             rd_all;
    logic [IDX_W-1:0] rd_ptr;
    logic [1:0]       exp_entries;
    logic [2:0]       exp_level;
    logic [1:0]       cmp_code;
    trace_entry_t     ev_in;
    trace_entry_t     ev_head;
    trace_entry_t     gold_in;
    trace_entry_t     exp_head;

    assign active   = (state == S_IDLE) || (state == S_RUN);
    assign ev_in    = '{pc: debug_wb_pc, addr: debug_wb_rf_addr, wdata: debug_wb_rf_wdata};
    assign gold_in  = '{pc: golden_pc, addr: golden_addr, wdata: golden_wdata};
    assign cmp_fire = (state == S_RUN) && !ev_empty && !exp_empty;
    assign cmp_code = cmp_entry(ev_head, exp_head);
    assign ev_push  = active && debug_wb_rf_wen && (debug_wb_rf_addr != 5'd0) && (!ev_full || cmp_fire);

    // Occupancy the expected queue will have after this edge; counting the pop lets reads stream one per cycle.
    assign exp_entries   = exp_full ? 2'd2 : (exp_empty ? 2'd0 : 2'd1);
    assign exp_level     = {1'b0, exp_entries} - {2'b0, cmp_fire} + {2'b0, inflight};
    assign golden_rd_en  = reset && active && !rd_all && (exp_level < 3'd2);
    assign golden_rd_idx = rd_ptr;

    assign pass = (state == S_PASS);
    assign fail = (state == S_FAIL);
    assign done = pass | fail;

    trace_fifo #(.WIDTH(ENTRY_W), .DEPTH(EVQ_DEPTH)) u_ev_q (
        .clk      (clk),
        .rst_n    (reset),
        .push     (ev_push),
        .push_dat (ev_in),
        .pop      (cmp_fire),
        .pop_dat  (ev_head),
        .empty    (ev_empty),
        .full     (ev_full)
    );

    trace_fifo #(.WIDTH(ENTRY_W), .DEPTH(2)) u_exp_q (
        .clk      (clk),
        .rst_n    (reset),
        .push     (inflight),
        .push_dat (gold_in),
        .pop      (cmp_fire),
        .pop_dat  (exp_head),
        .empty    (exp_empty),
        .full     (exp_full)
    );

    // Golden read pointer: stops on the last index and flags that the whole trace has been requested.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            rd_all   <= 1'b0;
            inflight <= 1'b0;
        end else begin
            inflight <= golden_rd_en;
            if (golden_rd_en) begin
                if (rd_ptr == IDX_W'(TRACE_LEN - 1))
                    rd_all <= 1'b1;
                else
                    rd_ptr <= rd_ptr + IDX_W'(1);
            end
        end
    end

    // Run FSM plus result registers; PASS and FAIL freeze everything until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            err_code       <= ERR_NONE;
            events_checked <= '0;
            mm_pc          <= '0;
            mm_got         <= '0;
            mm_exp         <= '0;
        end else begin
            case (state)
                S_IDLE: state <= S_RUN;
                S_RUN: begin
                    if (cmp_fire) begin
                        if (cmp_code != ERR_NONE) begin
                            state    <= S_FAIL;
                            err_code <= cmp_code;
                            mm_pc    <= ev_head.pc;
                            mm_got   <= ev_head.wdata;
                            mm_exp   <= exp_head.wdata;
                        end else begin
                            events_checked <= events_checked + 32'd1;
                            if (events_checked == 32'(TRACE_LEN - 1))
                                state <= S_PASS;
                        end
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_trace_checker.sv
// Bench for wb_trace_checker: three instances (trace lengths 3, 8, 4) share the CPU-side stimulus.
// Expected results are queued when a run is started; a monitor compares them when the selected instance raises done.
// Golden ROM model: entry i = {0xBFC00000+4*i, r(i+1), i+1}, data registered one cycle after the read strobe.
module tb_wb_trace_checker;

    typedef struct {
        logic        p;
        logic        f;
        logic [1:0]  err;
        logic [31:0] cnt;
        logic [31:0] mpc;
        logic [31:0] mgot;
        logic [31:0] mexp;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wb_pc;
    logic        wb_wen;
    logic [4:0]  wb_addr;
    logic [31:0] wb_wdata;

    logic        rd_en_o  [3];
    logic [9:0]  rd_idx_o [3];
    logic [31:0] gpc      [3];
    logic [4:0]  gaddr    [3];
    logic [31:0] gwd      [3];
    logic        done_o   [3];
    logic        pass_o   [3];
    logic        fail_o   [3];
    logic [1:0]  err_o    [3];
    logic [31:0] cnt_o    [3];
    logic [31:0] mmpc_o   [3];
    logic [31:0] mmgot_o  [3];
    logic [31:0] mmexp_o  [3];

    int   checks = 0;
    int   errors = 0;
    int   sel = 0;
    logic watch_idx = 1'b0;
    logic done_prev = 1'b0;
    exp_t sbq[$];
    int   idxq[$];
    exp_t m_e;

    always #5 clk = ~clk;

    wb_trace_checker #(.TRACE_LEN(3), .IDX_W(10), .EVQ_DEPTH(4)) dut0 (
        .clk(clk), .reset(reset), .debug_wb_pc(wb_pc), .debug_wb_rf_wen(wb_wen),
        .debug_wb_rf_addr(wb_addr), .debug_wb_rf_wdata(wb_wdata),
        .golden_rd_en(rd_en_o[0]), .golden_rd_idx(rd_idx_o[0]),
        .golden_pc(gpc[0]), .golden_addr(gaddr[0]), .golden_wdata(gwd[0]),
        .done(done_o[0]), .pass(pass_o[0]), .fail(fail_o[0]), .err_code(err_o[0]),
        .events_checked(cnt_o[0]), .mm_pc(mmpc_o[0]), .mm_got(mmgot_o[0]), .mm_exp(mmexp_o[0]));

    wb_trace_checker #(.TRACE_LEN(8), .IDX_W(10), .EVQ_DEPTH(4)) dut1 (
        .clk(clk), .reset(reset), .debug_wb_pc(wb_pc), .debug_wb_rf_wen(wb_wen),
        .debug_wb_rf_addr(wb_addr), .debug_wb_rf_wdata(wb_wdata),
        .golden_rd_en(rd_en_o[1]), .golden_rd_idx(rd_idx_o[1]),
        .golden_pc(gpc[1]), .golden_addr(gaddr[1]), .golden_wdata(gwd[1]),
        .done(done_o[1]), .pass(pass_o[1]), .fail(fail_o[1]), .err_code(err_o[1]),
        .events_checked(cnt_o[1]), .mm_pc(mmpc_o[1]), .mm_got(mmgot_o[1]), .mm_exp(mmexp_o[1]));

    wb_trace_checker #(.TRACE_LEN(4), .IDX_W(10), .EVQ_DEPTH(4)) dut2 (
        .clk(clk), .reset(reset), .debug_wb_pc(wb_pc), .debug_wb_rf_wen(wb_wen),
        .debug_wb_rf_addr(wb_addr), .debug_wb_rf_wdata(wb_wdata),
        .golden_rd_en(rd_en_o[2]), .golden_rd_idx(rd_idx_o[2]),
        .golden_pc(gpc[2]), .golden_addr(gaddr[2]), .golden_wdata(gwd[2]),
        .done(done_o[2]), .pass(pass_o[2]), .fail(fail_o[2]), .err_code(err_o[2]),
        .events_checked(cnt_o[2]), .mm_pc(mmpc_o[2]), .mm_got(mmgot_o[2]), .mm_exp(mmexp_o[2]));

    // Synchronous golden ROM per instance.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rd_en_o[k]) begin
                gpc[k]   <= 32'hBFC0_0000 + 32'({rd_idx_o[k], 2'b00});
                gaddr[k] <= 5'(rd_idx_o[k] + 10'd1);
                gwd[k]   <= 32'(rd_idx_o[k]) + 32'd1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] epc(input int k);
        return 32'hBFC0_0000 + 32'(4 * k);
    endfunction

    task automatic push_exp(input logic p, input logic f, input logic [1:0] e, input logic [31:0] c,
                            input logic [31:0] mpc, input logic [31:0] mgot, input logic [31:0] mexp);
        exp_t x;
        x.p = p; x.f = f; x.err = e; x.cnt = c; x.mpc = mpc; x.mgot = mgot; x.mexp = mexp;
        sbq.push_back(x);
    endtask

    task automatic cyc(input logic wen, input logic [4:0] a, input logic [31:0] pc, input logic [31:0] wd);
        wb_wen = wen; wb_addr = a; wb_pc = pc; wb_wdata = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic ev(input int k);
        cyc(1'b1, 5'(k + 1), epc(k), 32'(k + 1));
    endtask

    task automatic do_reset(input int s);
        reset = 1'b0;
        wb_wen = 1'b0; wb_addr = '0; wb_pc = '0; wb_wdata = '0;
        sel = s;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        wb_wen = 1'b0;
        while (sbq.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout_done: got no done after %0d cycles, required done on dut%0d", budget, sel);
            sbq.delete();
        end
    endtask

    task automatic chk_zero(input int k);
        chk("rst_done",   32'(done_o[k]),   32'd0);
        chk("rst_pass",   32'(pass_o[k]),   32'd0);
        chk("rst_fail",   32'(fail_o[k]),   32'd0);
        chk("rst_err",    32'(err_o[k]),    32'd0);
        chk("rst_cnt",    cnt_o[k],         32'd0);
        chk("rst_mm_pc",  mmpc_o[k],        32'd0);
        chk("rst_mm_got", mmgot_o[k],       32'd0);
        chk("rst_mm_exp", mmexp_o[k],       32'd0);
        chk("rst_rd_en",  32'(rd_en_o[k]),  32'd0);
        chk("rst_rd_idx", 32'(rd_idx_o[k]), 32'd0);
    endtask

    // Result monitor: on each rising done of the selected instance, pop and compare the expected outcome.
    always @(negedge clk) begin
        if (reset === 1'b1 && done_o[sel] === 1'b1 && !done_prev) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 on dut%0d, required no result pending", sel);
            end else begin
                m_e = sbq.pop_front();
                chk("pass",   32'(pass_o[sel]), 32'(m_e.p));
                chk("fail",   32'(fail_o[sel]), 32'(m_e.f));
                chk("err",    32'(err_o[sel]),  32'(m_e.err));
                chk("count",  cnt_o[sel],       m_e.cnt);
                chk("mm_pc",  mmpc_o[sel],      m_e.mpc);
                chk("mm_got", mmgot_o[sel],     m_e.mgot);
                chk("mm_exp", mmexp_o[sel],     m_e.mexp);
            end
        end
        done_prev <= (reset === 1'b1) && (done_o[sel] === 1'b1);
    end

    // Golden read monitor for the length-8 instance: each strobe must carry the next expected index.
    always @(negedge clk) begin
        if (watch_idx && reset === 1'b1 && rd_en_o[1] === 1'b1) begin
            if (idxq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_strobe: got rd_idx %0d, required no further strobe", rd_idx_o[1]);
            end else begin
                chk("rd_idx", 32'(rd_idx_o[1]), 32'(idxq.pop_front()));
            end
        end
    end

    initial begin
        reset = 1'b0;
        wb_wen = 1'b0; wb_addr = '0; wb_pc = '0; wb_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk_zero(k);

        // 1: three matching events, one every three cycles
        do_reset(0);
        push_exp(1'b1, 1'b0, 2'b00, 32'd3, 32'd0, 32'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            ev(k);
            idle(2);
        end
        wait_done(30);

        // 2: second event carries wrong data; third is ignored after FAIL
        do_reset(0);
        push_exp(1'b0, 1'b1, 2'b11, 32'd1, 32'hBFC0_0004, 32'd5, 32'd2);
        ev(0);
        idle(2);
        cyc(1'b1, 5'd2, epc(1), 32'd5);
        idle(2);
        ev(2);
        idle(4);
        wait_done(30);
        chk("t2_cnt_frozen", cnt_o[0], 32'd1);
        chk("t2_no_pass", 32'(pass_o[0]), 32'd0);
        chk("t2_fail_sticky", 32'(fail_o[0]), 32'd1);
        chk("t2_rd_en_off", 32'(rd_en_o[0]), 32'd0);

        // 3: non-events interleaved with the real trace
        do_reset(0);
        push_exp(1'b1, 1'b0, 2'b00, 32'd3, 32'd0, 32'd0, 32'd0);
        cyc(1'b0, 5'd3, epc(9), 32'hDEAD_BEEF);
        ev(0);
        cyc(1'b1, 5'd0, epc(7), 32'h77);
        cyc(1'b0, 5'd4, epc(1), 32'h99);
        ev(1);
        cyc(1'b1, 5'd0, epc(2), 32'h3);
        ev(2);
        cyc(1'b1, 5'd0, epc(3), 32'h4);
        wait_done(30);
        chk("t3_count", cnt_o[0], 32'd3);

        // 4: eight back-to-back events right after reset release
        reset = 1'b0;
        #1;
        idxq.delete();
        for (int k = 0; k < 8; k++) idxq.push_back(k);
        watch_idx = 1'b1;
        do_reset(1);
        push_exp(1'b1, 1'b0, 2'b00, 32'd8, 32'd0, 32'd0, 32'd0);
        for (int k = 0; k < 8; k++) ev(k);
        idle(1);
        chk("t4_pass_not_yet", 32'(pass_o[1]), 32'd0);
        idle(1);
        chk("t4_pass_on_time", 32'(pass_o[1]), 32'd1);
        wait_done(20);
        idle(4);
        chk("t4_all_idx_issued", 32'(idxq.size()), 32'd0);
        watch_idx = 1'b0;

        // 5: reset mid-run, then full replay
        do_reset(2);
        ev(0);
        ev(1);
        idle(2);
        chk("t5_two_checked", cnt_o[2], 32'd2);
        reset = 1'b0;
        #1;
        chk_zero(2);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        push_exp(1'b1, 1'b0, 2'b00, 32'd4, 32'd0, 32'd0, 32'd0);
        for (int k = 0; k < 4; k++) ev(k);
        wait_done(30);

        // 6a: pc and addr both wrong -> pc reported
        do_reset(0);
        push_exp(1'b0, 1'b1, 2'b01, 32'd0, 32'h1234_5678, 32'd1, 32'd1);
        cyc(1'b1, 5'd9, 32'h1234_5678, 32'd1);
        wait_done(30);

        // 6b: addr-only mismatch
        do_reset(0);
        push_exp(1'b0, 1'b1, 2'b10, 32'd0, 32'hBFC0_0000, 32'd1, 32'd1);
        cyc(1'b1, 5'd5, epc(0), 32'd1);
        wait_done(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
